data_mem_responder: RTL

Data-memory responder for the pipelined MIPS core's M stage. It serves the core's load and store requests with a same-cycle combinational read path, as the core expects. Stores are absorbed into a small in-order store buffer that drains into a single-port word array on cycles the port is free. It raises a stall to the hazard unit when a request cannot be completed in the current cycle.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/data_mem_responder_store_buffer_fifo.sv | 80 ++++++++
 rtl/data_mem_responder.sv | 86 ++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and sizing for the M-stage data-memory responder.
// The index width and the store-buffer entry layout are derived here from
// the default array depth; instances must keep MEM_WORDS equal to DMEM_MEM_WORDS.
package dmem_pkg;

    localparam int DMEM_MEM_WORDS = 64;
    localparam int DMEM_SB_DEPTH  = 4;
    localparam int IDX_W          = $clog2(DMEM_MEM_WORDS);
    localparam int SB_PTR_W       = $clog2(DMEM_SB_DEPTH);

    // One buffered store: word index plus the full data word.
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [31:0]      data;
    } sb_entry_t;

endpackage

// File: rtl/data_mem_responder_store_buffer_fifo.sv
// In-order store buffer: circular FIFO of {word index, data} with a count.
// Exposes a per-slot match vector for loads; with DMEM_STORE_FWD_EN defined it
// also provides the data of the youngest matching entry.
module store_buffer_fifo
    import dmem_pkg::*;
#(
    parameter  int DEPTH = DMEM_SB_DEPTH,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  sb_entry_t        push_entry,
    input  logic             pop,
    output sb_entry_t        head_entry,
    input  logic [IDX_W-1:0] match_idx,
    output logic [DEPTH-1:0] match_vec,
`ifdef DMEM_STORE_FWD_EN
    output logic [31:0]      fwd_data,
`endif
    output logic [PW:0]      count,
    output logic             full,
    output logic             empty
);

    sb_entry_t       entries [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW-1:0]   age [DEPTH];

    // Pointer and occupancy bookkeeping; push and pop are never both set.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Entry storage written at the tail on each accepted store.
    // NOTE: storage carries no reset; validity comes from head/count alone,
    // so clearing the entries would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) entries[tail] <= push_entry;
    end

    assign head_entry = entries[head];
    assign full       = (count == (PW+1)'(DEPTH));
    assign empty      = (count == '0);

    // A slot matches when it lies inside the live window and holds the index.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age[i]       = PW'(i) - head;
            match_vec[i] = ({1'b0, age[i]} < count) && (entries[i].idx == match_idx);
        end
    end

`ifdef DMEM_STORE_FWD_EN
    logic [PW-1:0] slot;

    // Walk oldest to youngest so the last hit (youngest match) wins.
    always_comb begin
        fwd_data = '0;
        slot     = head;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head + PW'(k);
            if (match_vec[slot]) fwd_data = entries[slot].data;
        end
    end
`endif

endmodule

// File: rtl/data_mem_responder.sv
// M-stage data-memory responder: combinational loads, buffered stores that
// drain into a single-port word array on cycles with no accepted request.
// Optional feature macro: DMEM_STORE_FWD_EN (store-to-load forwarding).
// Without it, a load that hits a buffered store stalls until that store drains.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = DMEM_MEM_WORDS,
    parameter int SB_DEPTH  = DMEM_SB_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_read_m,
    input  logic                      mem_write_m,
    input  logic [31:0]               alu_out_m,
    input  logic [31:0]               dmem_write_data_m,
    output logic [31:0]               dmem_read_data_m,
    output logic                      stall_m,
    output logic [$clog2(SB_DEPTH):0] sb_count,
    output logic                      sb_empty
);

    logic [31:0]         mem [MEM_WORDS];
    logic [IDX_W-1:0]    req_idx;
    logic [SB_DEPTH-1:0] match_vec;
    logic                sb_full;
    logic                load_block;
    logic                accepted;
    logic                push;
    logic                drain;
    sb_entry_t           push_entry;
    sb_entry_t           head_entry;
    logic                unused_addr;

    assign req_idx     = alu_out_m[IDX_W+1:2];
    assign unused_addr = ^{alu_out_m[31:IDX_W+2], alu_out_m[1:0]};
    assign push_entry  = '{idx: req_idx, data: dmem_write_data_m};

`ifdef DMEM_STORE_FWD_EN
    logic [31:0] fwd_data;
    assign load_block = 1'b0;
`else
    assign load_block = mem_read_m & (|match_vec);
`endif

    // A request that cannot finish this cycle stalls; the port is then free.
    assign stall_m  = ~reset & ((mem_write_m & sb_full) | load_block);
    assign accepted = (mem_read_m | mem_write_m) & ~stall_m;
    assign push     = ~reset & mem_write_m & ~stall_m;
    assign drain    = ~reset & ~sb_empty & ~accepted;

    store_buffer_fifo #(.DEPTH(SB_DEPTH)) u_sb (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (drain),
        .head_entry (head_entry),
        .match_idx  (req_idx),
        .match_vec  (match_vec),
`ifdef DMEM_STORE_FWD_EN
        .fwd_data   (fwd_data),
`endif
        .count      (sb_count),
        .full       (sb_full),
        .empty      (sb_empty)
    );

    // Oldest buffered store retires into the array on a free port cycle.
    always_ff @(posedge clk) begin
        if (drain) mem[head_entry.idx] <= head_entry.data;
    end

    // Load data is zero unless a load completes this cycle.
    always_comb begin
        dmem_read_data_m = '0;
        if (mem_read_m && !stall_m && !reset) begin
`ifdef DMEM_STORE_FWD_EN
            dmem_read_data_m = (|match_vec) ? fwd_data : mem[req_idx];
`else
            dmem_read_data_m = mem[req_idx];
`endif
        end
    end

endmodule
